// File: rtl/mult.sv
// Sequential unsigned shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// Uses the divider's init/done handshake, with fixed latency whatever the operand values.
module mult #(
  parameter int WIDTH       = 16,
  parameter int DONE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [WIDTH-1:0]     op_A,
  input  logic [WIDTH-1:0]     op_B,
  output logic                 done,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int HW = $clog2(DONE_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    ADD       = 3'd2,
    SHIFT     = 3'd3,
    CHECK_END = 3'd4,
    DONE      = 3'd5
  } state_e;

  state_e               state_q;
  logic                 init_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        count_q;
  logic [HW-1:0]        hold_q;
  logic                 done_q;
  logic                 busy_q;
  logic [2*WIDTH-1:0]   result_q;

  // Control FSM and datapath; init is flopped before IDLE acts on it, which sets the start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      init_q   <= 1'b0;
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      count_q  <= {CW{1'b0}};
      hold_q   <= {HW{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
    end else begin
      init_q <= init;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (init_q) begin
            state_q <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          mcand_q  <= {{WIDTH{1'b0}}, op_A};
          mplier_q <= op_B;
          acc_q    <= {(2*WIDTH){1'b0}};
          count_q  <= CW'(WIDTH);
          busy_q   <= 1'b1;
          state_q  <= ADD;
        end
        ADD: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end else begin
            acc_q <= acc_q;
          end
          state_q <= SHIFT;
        end
        SHIFT: begin
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q - CW'(1);
          state_q  <= CHECK_END;
        end
        CHECK_END: begin
          if (count_q == {CW{1'b0}}) begin
            result_q <= acc_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            hold_q   <= {HW{1'b0}};
            state_q  <= DONE;
          end else begin
            state_q  <= ADD;
          end
        end
        DONE: begin
          // done already spent its first cycle in CHECK_END, so the hold ends one short
          if (hold_q == HW'(DONE_CYCLES - 1)) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            hold_q  <= hold_q + HW'(1);
            state_q <= DONE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done   = done_q;
  assign busy   = busy_q;
  assign result = result_q;

endmodule

// File: tb/tb_mult.sv
// Bench for mult: a cycle-timeline model of the handshake plus directed and random operands.
module tb_mult;
  localparam int W  = 16;
  localparam int DC = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           init;
  logic [W-1:0]   op_A;
  logic [W-1:0]   op_B;
  logic           done;
  logic           busy;
  logic [2*W-1:0] result;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  logic [31:0] last_res = 32'd0;

  mult #(.WIDTH(W), .DONE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .init(init), .op_A(op_A), .op_B(op_B),
    .done(done), .busy(busy), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Timeline model: an accepted start at edge s gives busy over edges s+2..s+49,
  // done over s+50..s+53 with the product, and the next start is sampled from s+55 on.
  int          n = 0;
  int          s = 0;
  int          free_edge = 0;
  bit          active = 0;
  bit          init_prev = 0;
  logic [31:0] prod = 32'd0;
  logic [31:0] m_result = 32'd0;
  bit          m_busy = 0;
  bit          m_done = 0;

  always @(posedge clk) begin
    if (reset) begin
      n = 0; active = 0; free_edge = 0; init_prev = 0;
      m_result = 32'd0; m_busy = 0; m_done = 0;
    end else begin
      n++;
      if (active && n == s + 2) prod = 32'(op_A) * 32'(op_B);
      if (active && n == s + 50) m_result = prod;
      if (n >= free_edge && init_prev) begin
        s = n - 1; active = 1; free_edge = s + 55;
      end
      m_busy = active && (n >= s + 2) && (n <= s + 49);
      m_done = active && (n >= s + 50) && (n <= s + 53);
      init_prev = init;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("busy",   64'(busy),   64'(m_busy));
      check("done",   64'(done),   64'(m_done));
      check("result", 64'(result), 64'(m_result));
      check("busy_and_done", 64'(busy & done), 64'd0);
    end
  end

  task automatic wait_done(input string nm, output int k);
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) check({nm, "_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic wait_not_done(input string nm);
    int k;
    k = 0;
    while (done && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (done) check({nm, "_stuck"}, 64'(done), 64'd0);
  endtask

  // Called on a negedge; one-cycle init pulse, then latency, product and done width checks.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_lit);
    int k;
    int h;
    op_A = a; op_B = b; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 49) check({nm, "_prev_held"}, 64'(result), 64'(last_res));
    end
    check({nm, "_latency"}, 64'(k), 64'd50);
    check({nm, "_result"}, 64'(result), 64'(exp_lit));
    check({nm, "_model_pin"}, 64'(m_result), 64'(exp_lit));
    h = done ? 1 : 0;
    while (done && h < 20) begin
      @(negedge clk);
      if (done) h++;
    end
    check({nm, "_done_width"}, 64'(h), 64'(DC));
    check({nm, "_idle_busy"}, 64'(busy), 64'd0);
    last_res = exp_lit;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int seen;
    logic [15:0] a;
    logic [15:0] b;
    reset = 1'b1; init = 1'b0; op_A = 16'd0; op_B = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_done",   64'(done),   64'd0);
    check("rst_result", 64'(result), 64'd0);
    reset = 1'b0;
    chk_en = 1;
    repeat (2) @(negedge clk);

    run_op("p3x5",     16'd3,     16'd5,     32'h0000000F);
    run_op("pffff",    16'hFFFF,  16'hFFFF,  32'hFFFE0001);
    run_op("p8000x2",  16'h8000,  16'd2,     32'h00010000);
    run_op("zero_a",   16'd0,     16'h1234,  32'h00000000);
    run_op("p1x1",     16'd1,     16'd1,     32'h00000001);
    run_op("zero_b",   16'h1234,  16'd0,     32'h00000000);

    // operand changes and init pulses while busy and in the done window are ignored
    op_A = 16'd7; op_B = 16'd6; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (10) @(negedge clk);
    op_A = 16'd9; op_B = 16'd9; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (10) @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    wait_done("ign", k);
    check("ign_result", 64'(result), 64'd42);
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    wait_not_done("ign");
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    check("ign_no_second", 64'(seen), 64'd0);
    last_res = 32'd42;

    // init held high gives back-to-back operations
    op_A = 16'd2; op_B = 16'd3; init = 1'b1;
    wait_done("b2b1", k);
    check("b2b1_result", 64'(result), 64'd6);
    wait_not_done("b2b1");
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("b2b_second_busy", 64'(busy), 64'd1);
    wait_done("b2b2", k);
    check("b2b2_result", 64'(result), 64'd6);
    init = 1'b0;
    wait_not_done("b2b2");
    repeat (3) @(negedge clk);

    // reset part-way through an operation
    op_A = 16'hABCD; op_B = 16'h0123; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy",   64'(busy),   64'd0);
    check("midrst_done",   64'(done),   64'd0);
    check("midrst_result", 64'(result), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);
    last_res = 32'd0;
    run_op("after_rst", 16'd300, 16'd200, 32'd60000);

    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      run_op("rand", a, b, 32'(a) * 32'(b));
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult.md
Name: mult

Overview:
- Sequential unsigned shift-and-add multiplier; the inverse arithmetic counterpart of the team's sequential divider.
- Uses the same init/done handshake as the divider, so peripheral glue can drive either unit identically.
- Computes a WIDTH x WIDTH -> 2*WIDTH unsigned product with fixed latency, one partial-product step per bit.
- Sits behind the memory-mapped arithmetic peripheral; software writes operands, pulses init, then polls done.

Parameters:
- WIDTH, 16: operand width in bits; result is 2*WIDTH bits.
- DONE_CYCLES, 4: number of clk cycles done is held high after completion.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  start request; level-sampled in IDLE.
- op_A  input  WIDTH  multiplicand, unsigned.
- op_B  input  WIDTH  multiplier, unsigned.
- done  output  1  completion flag, registered.
- busy  output  1  high while an operation is in progress (LOAD..CHECK_END), registered.
- result  output  2*WIDTH  product, registered.

Behaviour:
- Reset (async, active-high): state=IDLE, done=0, busy=0, result=0, internal accumulator/shift registers/counter=0. Reset applies mid-operation: the operation is abandoned and no done pulse is produced.
- Internal regs: mcand (2*WIDTH, zero-extended op_A), mplier (WIDTH), acc (2*WIDTH), count (clog2(WIDTH)+1 bits).
- FSM states and transitions:
  - IDLE: done=0, busy=0. init=1 at the edge -> LOAD; else stay.
  - LOAD: mcand<=zero-extended op_A, mplier<=op_B, acc<=0, count<=WIDTH, busy<=1 -> ADD. Operands are captured only here; later changes to op_A/op_B are ignored.
  - ADD: if mplier[0]=1, acc<=acc+mcand (modulo 2^(2*WIDTH); cannot overflow for unsigned operands) -> SHIFT.
  - SHIFT: mcand<=mcand<<1, mplier<=mplier>>1 (zero fill), count<=count-1 -> CHECK_END.
  - CHECK_END: if count==0, result<=acc, done<=1, busy<=0 -> DONE; else -> ADD.
  - DONE: done held 1. Internal hold counter runs DONE_CYCLES cycles; on the last one done<=0 -> IDLE.
  - Unused or illegal state -> IDLE.
- Latency, WIDTH=16: init sampled at edge e0. done and result update at edge e0+2+3*WIDTH = e50. done stays high for DONE_CYCLES cycles and falls at e54; state is IDLE after e54.
- No early termination: latency is fixed regardless of operand values, including zero operands.
- init while busy or in DONE is ignored; no queuing.
- init still high when the FSM returns to IDLE starts a new operation at the next edge (level-sensitive). Consumers must drop init once done is seen.
- result holds its value until the next CHECK_END completion. It is not cleared at start; only reset clears it.
- busy and done are never high simultaneously.

Test Plan:
- op_A=3, op_B=5, 1-cycle init pulse -> busy high from edge after init; done and result=32'h0000000F at 50 edges after init edge; done high exactly 4 cycles; then IDLE.
- op_A=16'hFFFF, op_B=16'hFFFF -> result=32'hFFFE0001; op_A=16'h8000, op_B=2 -> result=32'h00010000.
- op_A=0, op_B=16'h1234 and op_A=16'h1234, op_B=0 -> result=0 with same 50-cycle latency; previous nonzero result remains visible until that completion.
- Start with op_A=7, op_B=6, then change operands to 9/9 and pulse init during busy -> result=42; no second operation; init pulses ignored.
- Hold init high continuously with op_A=2, op_B=3 -> back-to-back results of 6; second busy rises the edge after IDLE is re-entered.
- Assert reset 20 cycles into an operation -> done=0, busy=0, result=0 immediately (async); no done pulse. A fresh init after reset release gives the correct product.
